// File: rtl/data_collector.sv
// Narrow-to-wide packer: LANES narrow words in, one wide word out, lane 0 first.
// Define DATA_COLLECTOR_FLUSH_EN to add flush_i, which emits a zero-padded partial word.
module data_collector #(
    parameter int DATA_INPUT_WIDTH  = 32,
    parameter int DATA_OUTPUT_WIDTH = 256
) (
    input  logic                         clk,
    input  logic                         reset_n,
`ifdef DATA_COLLECTOR_FLUSH_EN
    input  logic                         flush_i,
`endif
    input  logic                         valid_i,
    input  logic [DATA_INPUT_WIDTH-1:0]  data_i,
    output logic                         ready_o,
    output logic [DATA_OUTPUT_WIDTH-1:0] data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DATA_OUTPUT_WIDTH/DATA_INPUT_WIDTH):0] fill_o
);

    localparam int LANES = DATA_OUTPUT_WIDTH / DATA_INPUT_WIDTH;
    localparam int CW    = $clog2(LANES) + 1;

    logic [CW-1:0]                cnt;
    logic [DATA_OUTPUT_WIDTH-1:0] asm_q;
    logic [DATA_OUTPUT_WIDTH-1:0] asm_next;
    logic                         last;
    logic                         slot_free;
    logic                         accept;
    logic                         complete;
    logic                         flush_go;
    logic                         emit;
    logic                         take;

    assign last      = (cnt == CW'(LANES - 1));
    assign slot_free = ~valid_o | ready_i;
    assign ready_o   = ~last | slot_free;
    assign accept    = valid_i & ready_o;
    assign complete  = accept & last;
    assign take      = valid_o & ready_i;

`ifdef DATA_COLLECTOR_FLUSH_EN
    assign flush_go = flush_i & slot_free & ((cnt != '0) | accept);
`else
    assign flush_go = 1'b0;
`endif

    // A completing or flushing edge always has a free output slot.
    assign emit = complete | flush_go;

    // Assembly contents including this cycle's word; unwritten lanes stay zero.
    always_comb begin
        asm_next = asm_q;
        for (int l = 0; l < LANES; l++) begin
            if (accept && cnt == CW'(l)) begin
                asm_next[l*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH] = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q <= '0;
            cnt   <= '0;
        end else if (emit) begin
            asm_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            asm_q <= asm_next;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (emit) begin
            data_o  <= asm_next;
            valid_o <= 1'b1;
        end else if (take) begin
            valid_o <= 1'b0;
        end
    end

    assign fill_o = cnt;

endmodule

// File: tb/tb_data_collector.sv
// Directed bench for data_collector with a packed-word scoreboard.
// Flush steps are built only when DATA_COLLECTOR_FLUSH_EN is defined.
module tb_data_collector;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         valid_i;
    logic [31:0]  data_i;
    logic         ready_o;
    logic [255:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic [3:0]   fill_o;
`ifdef DATA_COLLECTOR_FLUSH_EN
    logic         flush_i = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [255:0] expq[$];
    logic [255:0] part = '0;
    int lanes = 0;
    int takes = 0;
    int stalls = 0;
    logic acc_seen;
    logic [255:0] w1;
    logic [255:0] w2;
    logic [31:0]  d;

    data_collector #(
        .DATA_INPUT_WIDTH (32),
        .DATA_OUTPUT_WIDTH(256)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
`ifdef DATA_COLLECTOR_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .fill_o (fill_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        expq.delete();
        part  = '0;
        lanes = 0;
    endtask

    // Sample settled inputs/outputs before the edge, then advance one cycle.
    task automatic cyc();
        logic acc;
        #1;
        acc = valid_i & ready_o;
        if (valid_i && !ready_o) stalls++;
        if (valid_o && ready_i) begin
            takes++;
            chk("sb_pending", 256'(expq.size() > 0), 256'(1));
            if (expq.size() > 0) chk("sb_word", data_o, expq.pop_front());
        end
        if (acc) begin
            acc_seen = 1'b1;
            part[lanes*32 +: 32] = data_i;
            lanes++;
            if (lanes == 8) begin
                expq.push_back(part);
                part  = '0;
                lanes = 0;
            end
        end
`ifdef DATA_COLLECTOR_FLUSH_EN
        if (flush_i && (!valid_o || ready_i) && lanes != 0) begin
            expq.push_back(part);
            part  = '0;
            lanes = 0;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        valid_i  = 1'b1;
        data_i   = v;
        acc_seen = 1'b0;
        for (int n = 0; n < 40 && !acc_seen; n++) cyc();
        if (!acc_seen) chk("send_timeout", 256'(acc_seen), 256'(1));
        valid_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 256'(valid_o), 256'(0));
        chk("rst_fill", 256'(fill_o), 256'(0));
        chk("rst_ready", 256'(ready_o), 256'(1));
        chk("rst_data", data_o, 256'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1..8 -> one word one cycle after the 8th accept
        w1 = '0;
        for (int i = 1; i <= 8; i++) begin
            w1[(i-1)*32 +: 32] = 32'(i);
            valid_i = 1'b1;
            data_i  = 32'(i);
            #1;
            chk("t1_ready", 256'(ready_o), 256'(1));
            chk("t1_fill", 256'(fill_o), 256'(i - 1));
            chk("t1_novalid", 256'(valid_o), 256'(0));
            cyc();
        end
        valid_i = 1'b0;
        #1;
        chk("t1_valid", 256'(valid_o), 256'(1));
        chk("t1_data", data_o, w1);
        chk("t1_fill0", 256'(fill_o), 256'(0));
        cyc();
        chk("t1_taken", 256'(valid_o), 256'(0));

        // 24-word stream -> 3 words, no stalls
        takes  = 0;
        stalls = 0;
        for (int i = 0; i < 24; i++) send($urandom);
        cyc();
        chk("t2_takes", 256'(takes), 256'(3));
        chk("t2_stalls", 256'(stalls), 256'(0));

        // Backpressure: completing lane waits, then loads on the take edge
        w1 = '0;
        for (int i = 0; i < 8; i++) begin
            d = 32'(100 + i);
            w1[i*32 +: 32] = d;
            send(d);
        end
        ready_i = 1'b0;
        #1;
        chk("t3_valid", 256'(valid_o), 256'(1));
        w2 = '0;
        for (int i = 0; i < 7; i++) begin
            d = 32'(200 + i);
            w2[i*32 +: 32] = d;
            send(d);
        end
        w2[7*32 +: 32] = 32'd207;
        chk("t3_fill7", 256'(fill_o), 256'(7));
        valid_i = 1'b1;
        data_i  = 32'd207;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_blocked", 256'(ready_o), 256'(0));
            chk("t3_stable", data_o, w1);
            cyc();
        end
        ready_i = 1'b1;
        #1;
        chk("t3_ready_comb", 256'(ready_o), 256'(1));
        cyc();
        valid_i = 1'b0;
        #1;
        chk("t3_b2b_valid", 256'(valid_o), 256'(1));
        chk("t3_b2b_data", data_o, w2);
        cyc();

        // Reset mid-word discards partial lanes and pending output
        ready_i = 1'b0;
        for (int i = 0; i < 11; i++) send(32'(300 + i));
        #1;
        chk("t4_fill3", 256'(fill_o), 256'(3));
        chk("t4_pend", 256'(valid_o), 256'(1));
        reset_n = 1'b0;
        #1;
        chk("t4_rst_valid", 256'(valid_o), 256'(0));
        chk("t4_rst_fill", 256'(fill_o), 256'(0));
        clear_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready_i = 1'b1;
        w1 = '0;
        for (int i = 0; i < 8; i++) begin
            d = 32'(400 + i);
            w1[i*32 +: 32] = d;
            send(d);
        end
        #1;
        chk("t4_clean", data_o, w1);
        cyc();

`ifdef DATA_COLLECTOR_FLUSH_EN
        // Partial flush
        send(32'hA);
        send(32'hB);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        chk("f_valid", 256'(valid_o), 256'(1));
        chk("f_data", data_o, {192'd0, 32'hB, 32'hA});
        chk("f_fill", 256'(fill_o), 256'(0));
        cyc();
        // Flush with nothing held
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        chk("f_empty", 256'(valid_o), 256'(0));
        // Flush coinciding with completion
        takes = 0;
        for (int i = 0; i < 7; i++) send(32'(500 + i));
        valid_i = 1'b1;
        data_i  = 32'd507;
        flush_i = 1'b1;
        cyc();
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("f_full_valid", 256'(valid_o), 256'(1));
        cyc();
        #1;
        chk("f_no_extra", 256'(valid_o), 256'(0));
        repeat (3) cyc();
        chk("f_takes", 256'(takes), 256'(1));
`endif

        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (5) cyc();
        chk("drained", 256'(expq.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
